// File: rtl/instruction_fetch_tag_pkg.sv
// Shared I$ geometry, fetch address layout and the IFT<->IFD interface types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_tag_pkg;

  localparam int ICACHE_NUM_WAYS   = 2;
  localparam int ICACHE_WAY_BITS   = 1;
  localparam int ICACHE_NUM_SETS   = 64;
  localparam int ICACHE_SET_BITS   = 6;
  localparam int ICACHE_BLOCK_BITS = 5;   // 32-byte lines
  localparam int ICACHE_TAG_BITS   = 32 - ICACHE_SET_BITS - ICACHE_BLOCK_BITS;

  typedef logic [ICACHE_SET_BITS-1:0] set_idx_t;
  typedef logic [ICACHE_TAG_BITS-1:0] tag_t;

  localparam set_idx_t LAST_SET = set_idx_t'(ICACHE_NUM_SETS - 1);

  typedef struct packed {
    tag_t                         tag_idx;
    set_idx_t                     set_idx;
    logic [ICACHE_BLOCK_BITS-1:0] block_idx;
  } ifu_address_t;

  typedef struct packed {
    logic                       cache_miss;
    logic                       resume_fetch;
    logic [ICACHE_NUM_WAYS-1:0] update_tag_en;
    set_idx_t                   update_tag_set;
    tag_t                       update_tag;
  } ifd_ift_inf_t;

  typedef struct packed {
    ifu_address_t                     fetched_pc;
    logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_BITS-1:0] tags_read;
    logic [ICACHE_NUM_WAYS-1:0]       valid_bits;
  } ift_ifd_inf_t;

  typedef enum logic [1:0] {
    INVALIDATE = 2'd0,
    RUN        = 2'd1,
    STALL      = 2'd2
  } ift_state_t;

endpackage

// File: rtl/instruction_fetch_tag_way.sv
// One I$ tag way: a {valid, tag} RAM with the invalidation sweep muxed against refill installs.
// Latency: 1 cycle read; write and read to the same set in one cycle returns the old entry.
// Backpressure: none; the caller never issues a sweep write and an install in the same cycle.
// Ports: clk; sweep_we_i/sweep_set_i clear an entry; inst_we_i/inst_set_i/inst_tag_i install a
//        valid tag; rd_en_i/rd_set_i read; tag_o/valid_o the registered read data.
module bram_1r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Non-blocking write and read in one block give read-old-data on a collision.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module icache_tag_way
  import instruction_fetch_tag_pkg::*;
(
  input  logic     clk,
  input  logic     sweep_we_i,
  input  set_idx_t sweep_set_i,
  input  logic     inst_we_i,
  input  set_idx_t inst_set_i,
  input  tag_t     inst_tag_i,
  input  logic     rd_en_i,
  input  set_idx_t rd_set_i,
  output tag_t     tag_o,
  output logic     valid_o
);
  logic     we;
  set_idx_t waddr;
  logic [ICACHE_TAG_BITS:0] wdata;
  logic [ICACHE_TAG_BITS:0] rdata;

  // Sweep wins; installs are already blocked upstream while sweeping.
  assign we    = sweep_we_i | inst_we_i;
  assign waddr = sweep_we_i ? sweep_set_i : inst_set_i;
  assign wdata = sweep_we_i ? '0 : {1'b1, inst_tag_i};

  bram_1r1w #(
    .WIDTH(ICACHE_TAG_BITS + 1),
    .DEPTH(ICACHE_NUM_SETS),
    .AW   (ICACHE_SET_BITS)
  ) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .re_i   (rd_en_i),
    .raddr_i(rd_set_i),
    .rdata_o(rdata)
  );

  assign valid_o = rdata[ICACHE_TAG_BITS];
  assign tag_o   = rdata[ICACHE_TAG_BITS-1:0];
endmodule

// File: rtl/instruction_fetch_tag.sv
// IFT stage: owns the fetch PC and I$ tag RAMs; issues one tag read per cycle toward IFD.
// Latency: {pc, tags, valid bits} appear one cycle after issue; one fetch per cycle steady state.
// Backpressure: IFD miss freezes fetch (STALL) until resume_fetch; redirects squash in-flight reads.
// Ports: clk, rst (sync, active-high); wb_do_branch/wb_branch_target redirect; flush_req invalidates;
//        ifd_ift_inf miss/resume/install from IFD; ift_valid + ift_ifd_inf to IFD; flush_busy while sweeping.
module instruction_fetch_tag
  import instruction_fetch_tag_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_do_branch,
  input  logic [31:0]  wb_branch_target,
  input  logic         flush_req,
  input  ifd_ift_inf_t ifd_ift_inf,
  output logic         ift_valid,
  output ift_ifd_inf_t ift_ifd_inf,
  output logic         flush_busy
);
  ift_state_t   state_q, state_d;
  set_idx_t     sweep_ctr_q, sweep_ctr_d;
  logic [31:0]  pc_q, pc_d;
  ifu_address_t fetched_pc_q, fetched_pc_d;
  logic         valid_q, valid_d;
  logic         flush_pend_q, flush_pend_d;

  logic         miss;
  logic         rd_en;
  logic         sweep_we;
  logic         inst_ok;
  logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_BITS-1:0] tags_rd;
  logic [ICACHE_NUM_WAYS-1:0] vbits_rd;

  // A redirect in the same cycle overrides the miss.
  assign miss = ifd_ift_inf.cache_miss & ~wb_do_branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INVALIDATE;
      sweep_ctr_q  <= '0;
      pc_q         <= RESET_PC;
      fetched_pc_q <= ifu_address_t'(RESET_PC);
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_ctr_q  <= sweep_ctr_d;
      pc_q         <= pc_d;
      fetched_pc_q <= fetched_pc_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INVALIDATE: if (!flush_req && sweep_ctr_q == LAST_SET) state_d = RUN;
      RUN: begin
        if (flush_req)  state_d = INVALIDATE;
        else if (miss)  state_d = STALL;
      end
      STALL: begin
        // A flush seen while stalled is honoured only once IFD lets fetch resume.
        if (ifd_ift_inf.resume_fetch)
          state_d = (flush_pend_q | flush_req) ? INVALIDATE : RUN;
      end
      default: state_d = INVALIDATE;
    endcase
  end

  always_comb begin
    sweep_ctr_d  = '0;
    pc_d         = pc_q;
    fetched_pc_d = fetched_pc_q;
    valid_d      = 1'b0;
    flush_pend_d = flush_pend_q;
    case (state_q)
      INVALIDATE: begin
        if (!flush_req && sweep_ctr_q != LAST_SET)
          sweep_ctr_d = sweep_ctr_q + set_idx_t'(1);
      end
      RUN: begin
        if (!wb_do_branch) begin
          if (miss) begin
            pc_d = fetched_pc_q;          // rewind to the missed fetch
          end else begin
            fetched_pc_d = pc_q;
            valid_d      = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end
      end
      STALL: begin
        if (flush_req)                 flush_pend_d = 1'b1;
        if (ifd_ift_inf.resume_fetch)  flush_pend_d = 1'b0;
      end
      default: ;
    endcase
    if (wb_do_branch) pc_d = wb_branch_target;
  end

  always_comb begin
    flush_busy = (state_q == INVALIDATE);
    sweep_we   = (state_q == INVALIDATE);
    rd_en      = (state_q == RUN);
  end

  // Installs landing mid-sweep are dropped; IFD will refetch the line.
  assign inst_ok = (state_q != INVALIDATE) & ~rst;

  for (genvar w = 0; w < ICACHE_NUM_WAYS; w++) begin : g_way
    icache_tag_way u_way (
      .clk        (clk),
      .sweep_we_i (sweep_we),
      .sweep_set_i(sweep_ctr_q),
      .inst_we_i  (inst_ok & ifd_ift_inf.update_tag_en[w]),
      .inst_set_i (ifd_ift_inf.update_tag_set),
      .inst_tag_i (ifd_ift_inf.update_tag),
      .rd_en_i    (rd_en),
      .rd_set_i   (pc_q[ICACHE_BLOCK_BITS +: ICACHE_SET_BITS]),
      .tag_o      (tags_rd[w]),
      .valid_o    (vbits_rd[w])
    );
  end

  assign ift_valid   = valid_q;
  assign ift_ifd_inf = {fetched_pc_q, tags_rd, vbits_rd};
endmodule

// File: tb/tb_instruction_fetch_tag.sv
module tb_instruction_fetch_tag;
  import instruction_fetch_tag_pkg::*;

  localparam int W  = ICACHE_NUM_WAYS;
  localparam int S  = ICACHE_NUM_SETS;
  localparam int TB = ICACHE_TAG_BITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_do_branch;
  logic [31:0]  wb_branch_target;
  logic         flush_req;
  ifd_ift_inf_t ifd_ift_inf;
  logic         ift_valid;
  ift_ifd_inf_t ift_ifd_inf;
  logic         flush_busy;

  instruction_fetch_tag #(.RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_do_branch    (wb_do_branch),
    .wb_branch_target(wb_branch_target),
    .flush_req       (flush_req),
    .ifd_ift_inf     (ifd_ift_inf),
    .ift_valid       (ift_valid),
    .ift_ifd_inf     (ift_ifd_inf),
    .flush_busy      (flush_busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: cache contents as plain arrays, fetch behaviour as mode flags.
  bit          cv [W][S];
  logic [TB-1:0] ct [W][S];
  bit          m_inv, m_stall, m_pend, m_vld;
  int          m_idx;
  logic [31:0] m_pc, m_fpc;
  logic [W-1:0] m_vb;
  logic [W-1:0][TB-1:0] m_tags;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    wb_do_branch = 1'b0;
    wb_branch_target = '0;
    flush_req = 1'b0;
    ifd_ift_inf = '0;
  endtask

  task automatic model_install();
    for (int w = 0; w < W; w++)
      if (ifd_ift_inf.update_tag_en[w]) begin
        cv[w][ifd_ift_inf.update_tag_set] = 1'b1;
        ct[w][ifd_ift_inf.update_tag_set] = ifd_ift_inf.update_tag;
      end
  endtask

  task automatic model_step();
    logic [W-1:0] rvb;
    logic [W-1:0][TB-1:0] rt;
    bit nv;
    int s;
    nv = 1'b0;
    if (rst) begin
      m_inv = 1; m_idx = 0; m_stall = 0; m_pend = 0; m_pc = 32'h0; m_vld = 0;
      return;
    end
    if (m_inv) begin
      for (int w = 0; w < W; w++) begin cv[w][m_idx] = 1'b0; ct[w][m_idx] = '0; end
      if (m_idx == S - 1) begin m_inv = 0; m_idx = 0; end
      else m_idx = m_idx + 1;
      if (wb_do_branch) m_pc = wb_branch_target;
      if (flush_req) begin m_inv = 1; m_idx = 0; end
    end else if (m_stall) begin
      model_install();
      if (wb_do_branch) m_pc = wb_branch_target;
      if (flush_req) m_pend = 1;
      if (ifd_ift_inf.resume_fetch) begin
        m_stall = 0;
        if (m_pend) begin m_inv = 1; m_idx = 0; m_pend = 0; end
      end
    end else begin
      s = int'((m_pc >> 5) % S);
      for (int w = 0; w < W; w++) begin rvb[w] = cv[w][s]; rt[w] = ct[w][s]; end
      model_install();
      if (wb_do_branch) begin
        m_pc = wb_branch_target;
        if (flush_req) begin m_inv = 1; m_idx = 0; end
      end else if (ifd_ift_inf.cache_miss) begin
        m_stall = 1; m_pc = m_fpc;
      end else begin
        nv = 1; m_fpc = m_pc; m_vb = rvb; m_tags = rt; m_pc = m_pc + 32'd4;
      end
    end
    m_vld = nv;
  endtask

  // One clock: model consumes the driven inputs, DUT outputs checked 1 time unit after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("ift_valid", ift_valid, m_vld);
    chk("flush_busy", flush_busy, m_inv);
    if (m_vld) begin
      chk("fetched_pc", ift_ifd_inf.fetched_pc, m_fpc);
      chk("valid_bits", ift_ifd_inf.valid_bits, m_vb);
      chk("tags_read", ift_ifd_inf.tags_read, m_tags);
    end
    idle();
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin cyc(); n++; end while (ift_valid !== 1'b1 && n < max);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    idle();
    rst = 1'b1; cyc();
    rst = 1'b1; cyc();
    chk("reset_valid", ift_valid, 0);
    chk("reset_busy", flush_busy, 1);

    // Reset release: sweep then 0x0, 0x4, 0x8
    wait_valid(200, n);
    chk("first_fetch_latency", n, 65);
    chk("pc_0", ift_ifd_inf.fetched_pc, 32'h0);
    chk("vb_after_reset", ift_ifd_inf.valid_bits, 0);
    cyc(); chk("pc_4", ift_ifd_inf.fetched_pc, 32'h4);
    cyc(); chk("pc_8", ift_ifd_inf.fetched_pc, 32'h8);

    // Redirect in RUN
    wb_do_branch = 1; wb_branch_target = 32'h1000; cyc();
    chk("redir_squash", ift_valid, 0);
    cyc(); chk("redir_valid", ift_valid, 1); chk("redir_pc", ift_ifd_inf.fetched_pc, 32'h1000);
    cyc(); chk("redir_pc_next", ift_ifd_inf.fetched_pc, 32'h1004);

    // Miss at 0x0, install way0 set0 tag0, resume
    wb_do_branch = 1; wb_branch_target = 32'h0; cyc(); cyc();
    chk("miss_setup_pc", ift_ifd_inf.fetched_pc, 32'h0);
    ifd_ift_inf.cache_miss = 1; cyc();
    chk("miss_squash", ift_valid, 0);
    ifd_ift_inf.update_tag_en = 2'b01; ifd_ift_inf.update_tag_set = 0; ifd_ift_inf.update_tag = 0; cyc();
    chk("stall_hold", ift_valid, 0);
    ifd_ift_inf.resume_fetch = 1; cyc();
    cyc();
    chk("refetch_pc", ift_ifd_inf.fetched_pc, 32'h0);
    chk("refetch_vb0", ift_ifd_inf.valid_bits[0], 1);
    chk("refetch_tag0", ift_ifd_inf.tags_read[0], 0);

    // Redirect during STALL
    ifd_ift_inf.cache_miss = 1; cyc();
    wb_do_branch = 1; wb_branch_target = 32'h2000; cyc();
    ifd_ift_inf.resume_fetch = 1; cyc();
    cyc(); chk("stall_redir_pc", ift_ifd_inf.fetched_pc, 32'h2000);

    // Install both ways of set 5 and hit them
    ifd_ift_inf.cache_miss = 1; cyc();
    ifd_ift_inf.update_tag_en = 2'b10; ifd_ift_inf.update_tag_set = 5; ifd_ift_inf.update_tag = 21'h1ABCD; cyc();
    ifd_ift_inf.update_tag_en = 2'b01; ifd_ift_inf.update_tag_set = 5; ifd_ift_inf.update_tag = 21'h12345; cyc();
    a = {21'h12345, 6'd5, 5'd0};
    wb_do_branch = 1; wb_branch_target = a; ifd_ift_inf.resume_fetch = 1; cyc();
    cyc();
    chk("install_vb", ift_ifd_inf.valid_bits, 2'b11);
    chk("install_tags", ift_ifd_inf.tags_read, {21'h1ABCD, 21'h12345});

    // Flush in RUN
    wb_do_branch = 1; flush_req = 1; wb_branch_target = 32'h40; cyc();
    chk("flush_busy_start", flush_busy, 1);
    wait_valid(200, n);
    chk("flush_latency", n, 65);
    chk("flush_pc", ift_ifd_inf.fetched_pc, 32'h40);
    chk("flush_vb", ift_ifd_inf.valid_bits, 0);
    wb_do_branch = 1; wb_branch_target = a; cyc(); cyc();
    chk("flush_wiped", ift_ifd_inf.valid_bits, 0);

    // Flush during STALL is deferred until resume
    ifd_ift_inf.cache_miss = 1; cyc();
    wb_do_branch = 1; flush_req = 1; wb_branch_target = 32'h80; cyc();
    chk("flush_deferred", flush_busy, 0);
    cyc(); chk("flush_still_deferred", flush_busy, 0);
    ifd_ift_inf.resume_fetch = 1; cyc();
    chk("flush_on_resume", flush_busy, 1);
    wait_valid(200, n);
    chk("deferred_latency", n, 65);
    chk("deferred_pc", ift_ifd_inf.fetched_pc, 32'h80);

    // PC wrap at 2^32
    wb_do_branch = 1; wb_branch_target = 32'hFFFF_FFF8; cyc(); cyc();
    chk("wrap_pc0", ift_ifd_inf.fetched_pc, 32'hFFFF_FFF8);
    cyc(); chk("wrap_pc1", ift_ifd_inf.fetched_pc, 32'hFFFF_FFFC);
    cyc(); chk("wrap_pc2", ift_ifd_inf.fetched_pc, 32'h0);

    // Reset mid-sweep with an install on the bus
    wb_do_branch = 1; flush_req = 1; wb_branch_target = 32'h100; cyc();
    repeat (10) cyc();
    rst = 1; ifd_ift_inf.update_tag_en = 2'b11; ifd_ift_inf.update_tag_set = 3; ifd_ift_inf.update_tag = 5; cyc();
    chk("rst_sweep_busy", flush_busy, 1);
    wait_valid(200, n);
    chk("rst_sweep_latency", n, 65);
    chk("rst_sweep_pc", ift_ifd_inf.fetched_pc, 32'h0);

    // Reset mid-stall
    ifd_ift_inf.cache_miss = 1; cyc();
    rst = 1; ifd_ift_inf.update_tag_en = 2'b11; ifd_ift_inf.update_tag_set = 0; ifd_ift_inf.update_tag = 7; cyc();
    wait_valid(200, n);
    chk("rst_stall_latency", n, 65);
    chk("rst_stall_pc", ift_ifd_inf.fetched_pc, 32'h0);
    chk("rst_stall_vb", ift_ifd_inf.valid_bits, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1;
      end else begin
        if ($urandom_range(0, 15) == 0) begin
          wb_do_branch = 1;
          if ($urandom_range(0, 3) == 0)
            wb_branch_target = 32'hFFFF_FF00 + ($urandom_range(0, 63) << 2);
          else
            wb_branch_target = $urandom_range(0, 2047) << 2;
          if ($urandom_range(0, 7) == 0) flush_req = 1;
        end else if (m_vld && $urandom_range(0, 7) == 0) begin
          ifd_ift_inf.cache_miss = 1;
        end
        if (m_stall && $urandom_range(0, 3) == 0) ifd_ift_inf.resume_fetch = 1;
        if ($urandom_range(0, 5) == 0) begin
          ifd_ift_inf.update_tag_en  = 2'($urandom_range(1, 3));
          ifd_ift_inf.update_tag_set = 6'($urandom_range(0, 63));
          ifd_ift_inf.update_tag     = 21'($urandom_range(0, 3));
        end
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_tag.md
Name: instruction_fetch_tag

Overview:
- Front stage of the instruction fetch unit (IFT), directly upstream of the I$ data/refill stage (IFD).
- Owns the fetch PC, the per-way I$ tag/valid RAMs and the fetch stall/redirect control.
- Each cycle it issues one word-aligned PC into a tag read and presents `{pc, tags, valid bits}` to IFD one cycle later.
- It freezes on IFD-reported misses, installs refilled tags, and runs an invalidation sweep after reset and on flush.

Parameters:
- RESET_PC, 32'h0000_0000, first PC fetched after reset.
- I$ geometry (ICACHE_NUM_WAYS/_WAY_BITS, ICACHE_NUM_SETS/_SET_BITS, tag width) comes from the defines package, not from parameters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_do_branch  in  1  redirect (branch or mispredict) from WB
- wb_branch_target  in  32  redirect PC, word-aligned
- flush_req  in  1  I$ invalidate (FENCE.I); only ever asserted in the same cycle as wb_do_branch
- ifd_ift_inf  in  ifd_ift_inf_t  `{cache_miss, resume_fetch, update_tag_en[WAYS], update_tag_set, update_tag}`
- ift_valid  out  1  ift_ifd_inf holds a live fetch
- ift_ifd_inf  out  ift_ifd_inf_t  `{fetched_pc (ifu_address_t), tags_read[WAYS], valid_bits[WAYS]}`
- flush_busy  out  1  high while the invalidation sweep runs

Behaviour:
- Reset values:
  - state=INVALIDATE, sweep_ctr=0, pc_reg=RESET_PC.
  - ift_valid=0, flush_busy=1, flush pending flag=0.
- Storage:
  - One bram_1r1w per way, ICACHE_NUM_SETS deep, entry `{valid, tag}`.
  - Read latency 1; a write and a read in the same cycle to the same address return the old data.
- States:
  - INVALIDATE:
    - Write `{0, 0}` to set sweep_ctr in all ways each cycle; sweep_ctr increments.
    - No reads issued; ift_valid=0.
    - When sweep_ctr == ICACHE_NUM_SETS-1, the write happens, sweep_ctr returns to 0, and the next state is RUN.
    - flush_busy=1 throughout.
  - RUN:
    - Issue a tag read at pc_reg.set_idx.
    - Register fetched_pc<=pc_reg, ift_valid<=1, pc_reg<=pc_reg+4. The 32-bit add wraps at 2^32.
    - tags_read and valid_bits are the RAM outputs aligned with fetched_pc.
  - STALL:
    - No reads issued; ift_valid=0; pc_reg is held.
    - On ifd_ift_inf.resume_fetch, go to RUN. The first issue happens in the following cycle.
- Miss:
  - Trigger: ifd_ift_inf.cache_miss=1, which only occurs with ift_valid=1.
  - Response: state<=STALL, pc_reg<=fetched_pc (rewind), ift_valid<=0.
  - The read issued in the miss cycle is squashed.
- Tag install:
  - Any update_tag_en[w]=1 writes `{1, update_tag}` at update_tag_set in way w, in every state except INVALIDATE.
  - IFD raises resume one cycle after the install, so the re-issued read sees the new tag.
- Redirect (wb_do_branch):
  - Sets pc_reg<=wb_branch_target and ift_valid<=0 in every state, so the in-flight read is squashed.
  - Priority: wb_do_branch beats cache_miss; IFD already masks the miss in that cycle.
  - In RUN: the target is issued at t+1, so ift_valid=1 with fetched_pc=target at t+2.
  - In STALL: state is unchanged; after resume the fetch restarts at the new target.
- Flush:
  - flush_req in RUN: next state is INVALIDATE, sweep_ctr=0, pc_reg<=wb_branch_target.
  - flush_req in STALL: sets the pending flag; on resume the state enters INVALIDATE instead of RUN, and the flag clears.
  - flush_req in INVALIDATE: restarts the sweep at 0.
  - A tag install arriving during INVALIDATE is dropped; the line is refetched later.
- Reset mid-operation (sweep, stall or run) returns to the reset values in the next cycle. Install writes are suppressed while rst=1.
- Latency:
  - Steady state is one fetch per cycle.
  - First ift_valid after reset is ICACHE_NUM_SETS+1 cycles after the first cycle with rst low.

Decomposition:
- defines package holds:
  - ICACHE_* constants.
  - ifu_address_t `{tag_idx, set_idx, block_idx}` packed to 32 bits.
  - ift_ifd_inf_t and ifd_ift_inf_t.
  - ift_state_t `{INVALIDATE, RUN, STALL}`.
- Sub-module: icache_tag_way, which wraps one bram_1r1w with `{valid, tag}` packing and muxes the sweep write against the install write. It is instantiated ICACHE_NUM_WAYS times by a generate loop.

Test Plan (2 ways, 64 sets, 32B lines, RESET_PC=0x0):
- Reset release: flush_busy=1 for 64 cycles, then ift_valid=1 with fetched_pc 0x0, 0x4, 0x8 on consecutive cycles; all valid_bits=0.
- Miss at fetched_pc=0x0:
  - Next cycle ift_valid=0 and the state is STALL.
  - Install way0 set0 tag0, then resume.
  - 2 cycles after resume: fetched_pc=0x0 with valid_bits[0]=1 and tags_read[0]=0.
- Redirect in RUN to 0x1000 at cycle t: ift_valid=0 at t+1; ift_valid=1 with fetched_pc=0x1000 at t+2, then 0x1004.
- Redirect during STALL to 0x2000, then resume: fetching restarts at 0x2000, not at the missed PC.
- flush_req with wb_do_branch to 0x40 after installing tags:
  - 64 sweep cycles follow.
  - First fetch is 0x40 with all valid_bits=0.
  - flush during STALL is deferred until resume.
- rst asserted mid-sweep and mid-stall: sweep restarts at set 0, pc_reg=0x0, and no spurious install write occurs.
